// File: rtl/game_overlay.sv
// game_overlay: two-stage video overlay that draws a START / END / PAUSE
// message box on top of a VGA pixel stream, dims the background in PAUSE
// and passes the stream through untouched in PLAY.
// Optional feature macro: GAME_OVERLAY_BLINK_EN (blinking message text).
module game_overlay #(
    parameter int          HOR_PIXELS   = 1024,
    parameter int          VER_PIXELS   = 768,
    parameter int          RECT_X       = HOR_PIXELS / 4,
    parameter int          RECT_Y       = VER_PIXELS / 3,
    parameter int          RECT_W       = HOR_PIXELS / 2,
    parameter int          RECT_H       = VER_PIXELS / 3,
    parameter int          TXT_DX       = 32,
    parameter int          TXT_DY       = 64,
    parameter int          SCALE_LOG2   = 2,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] FG           = 12'hFF0,
    parameter logic [11:0] BG           = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  game_active,
    input  logic [10:0] vga_in_hcount,
    input  logic [10:0] vga_in_vcount,
    input  logic        vga_in_hsync,
    input  logic        vga_in_vsync,
    input  logic        vga_in_hblnk,
    input  logic        vga_in_vblnk,
    input  logic [11:0] vga_in_rgb,
    output logic [10:0] vga_out_hcount,
    output logic [10:0] vga_out_vcount,
    output logic        vga_out_hsync,
    output logic        vga_out_vsync,
    output logic        vga_out_hblnk,
    output logic        vga_out_vblnk,
    output logic [11:0] vga_out_rgb
);

    typedef enum logic [1:0] {
        MODE_START = 2'd0,
        MODE_PLAY  = 2'd1,
        MODE_END   = 2'd2,
        MODE_PAUSE = 2'd3
    } mode_t;

    localparam logic [31:0] BOX_X0 = 32'(RECT_X);
    localparam logic [31:0] BOX_X1 = 32'(RECT_X + RECT_W);
    localparam logic [31:0] BOX_Y0 = 32'(RECT_Y);
    localparam logic [31:0] BOX_Y1 = 32'(RECT_Y + RECT_H);
    localparam logic [31:0] TXT_X  = 32'(RECT_X + TXT_DX);
    localparam logic [31:0] TXT_Y  = 32'(RECT_Y + TXT_DY);
    localparam int          CELL_SHIFT = 3 + SCALE_LOG2;

    localparam logic [3:0] CH_S = 4'd0, CH_T = 4'd1, CH_A = 4'd2, CH_R = 4'd3,
                           CH_E = 4'd4, CH_N = 4'd5, CH_D = 4'd6, CH_P = 4'd7,
                           CH_U = 4'd8, CH_NONE = 4'd15;

    // 8x8 font ROM; row 0 is the top byte, column 0 is the MSB of each byte.
    function automatic logic [63:0] font_glyph(input logic [3:0] code);
        logic [63:0] g;
        case (code)
            CH_S:    g = 64'h3C66603C06663C00;
            CH_T:    g = 64'h7E18181818181800;
            CH_A:    g = 64'h183C66667E666600;
            CH_R:    g = 64'h7C66667C6C666600;
            CH_E:    g = 64'h7E60607C60607E00;
            CH_N:    g = 64'h66767E7E6E666600;
            CH_D:    g = 64'h786C6666666C7800;
            CH_P:    g = 64'h7C66667C60606000;
            CH_U:    g = 64'h6666666666663C00;
            default: g = 64'h0000000000000000;
        endcase
        return g;
    endfunction

    // Character at position idx of the message shown in mode m; CH_NONE past the end.
    function automatic logic [3:0] msg_char(input mode_t m, input logic [31:0] idx);
        logic [3:0] c;
        c = CH_NONE;
        case (m)
            MODE_START: begin
                case (idx)
                    32'd0:   c = CH_S;
                    32'd1:   c = CH_T;
                    32'd2:   c = CH_A;
                    32'd3:   c = CH_R;
                    32'd4:   c = CH_T;
                    default: c = CH_NONE;
                endcase
            end
            MODE_END: begin
                case (idx)
                    32'd0:   c = CH_E;
                    32'd1:   c = CH_N;
                    32'd2:   c = CH_D;
                    default: c = CH_NONE;
                endcase
            end
            MODE_PAUSE: begin
                case (idx)
                    32'd0:   c = CH_P;
                    32'd1:   c = CH_A;
                    32'd2:   c = CH_U;
                    32'd3:   c = CH_S;
                    32'd4:   c = CH_E;
                    default: c = CH_NONE;
                endcase
            end
            default: c = CH_NONE;
        endcase
        return c;
    endfunction

    // Halve every 4-bit channel (12'hFFF -> 12'h777).
    function automatic logic [11:0] dim_rgb(input logic [11:0] c);
        return (c >> 1) & 12'h777;
    endfunction

    // ---------------- mode register and frame bookkeeping ----------------
    mode_t       r_mode;
    mode_t       w_mode;
    logic        w_frame_start;
    logic        w_visible;

    assign w_frame_start = (vga_in_hcount == 11'd0) && (vga_in_vcount == 11'd0);
    // The pixel at the frame start already belongs to the new frame, so it
    // is decoded with the freshly loaded mode.
    assign w_mode = w_frame_start ? mode_t'(game_active) : r_mode;

    // Mode is sampled from game_active only at the first pixel of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= MODE_START;
        end else begin
            r_mode <= w_mode;
        end
    end

`ifdef GAME_OVERLAY_BLINK_EN
    localparam int                 CNT_W    = (BLINK_FRAMES < 1) ? 1 : $clog2(2 * BLINK_FRAMES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(2 * BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0]   CNT_HALF = CNT_W'(BLINK_FRAMES);

    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] w_frame_cnt_next;

    // Next frame count: restart on a mode change so the text shows at once.
    always_comb begin
        w_frame_cnt_next = r_frame_cnt;
        if (w_frame_start) begin
            if (mode_t'(game_active) != r_mode) begin
                w_frame_cnt_next = {CNT_W{1'b0}};
            end else if (r_frame_cnt == CNT_LAST) begin
                w_frame_cnt_next = {CNT_W{1'b0}};
            end else begin
                w_frame_cnt_next = r_frame_cnt + CNT_W'(1);
            end
        end else begin
            w_frame_cnt_next = r_frame_cnt;
        end
    end

    // Frame counter that paces the blink half-periods.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= {CNT_W{1'b0}};
        end else begin
            r_frame_cnt <= w_frame_cnt_next;
        end
    end

    assign w_visible = (w_frame_cnt_next < CNT_HALF);
`else
    assign w_visible = 1'b1;
`endif

    // ---------------- stage 1: region and glyph decode ----------------
    logic [31:0] w_h, w_v, w_dx, w_dy, w_char_idx;
    logic [2:0]  w_col, w_row;
    logic [63:0] w_glyph;
    logic        w_in_box, w_in_text_area, w_text_on;

    assign w_h      = {21'd0, vga_in_hcount};
    assign w_v      = {21'd0, vga_in_vcount};
    assign w_in_box = (w_h >= BOX_X0) && (w_h < BOX_X1) && (w_v >= BOX_Y0) && (w_v < BOX_Y1);
    // Origin test happens before subtracting, so w_dx/w_dy never wrap when used.
    assign w_in_text_area = (w_h >= TXT_X) && (w_v >= TXT_Y);
    assign w_dx       = w_h - TXT_X;
    assign w_dy       = w_v - TXT_Y;
    assign w_char_idx = w_dx >> CELL_SHIFT;
    assign w_col      = 3'((w_dx >> SCALE_LOG2) & 32'd7);
    // Row wraps every glyph cell, so the message repeats down the box until clipped.
    assign w_row      = 3'((w_dy >> SCALE_LOG2) & 32'd7);
    assign w_glyph    = font_glyph(msg_char(w_mode, w_char_idx));
    // {~row,~col} == 63 - (row*8 + col): MSB-first bit of the glyph.
    assign w_text_on  = w_in_box && w_in_text_area && w_visible && w_glyph[{~w_row, ~w_col}];

    logic [10:0] r1_hcount, r1_vcount;
    logic        r1_hsync, r1_vsync, r1_hblnk, r1_vblnk;
    logic [11:0] r1_rgb;
    mode_t       r1_mode;
    logic        r1_in_box, r1_text_on;

    // Stage 1 register: delayed video fields plus the decoded pixel class.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_hcount  <= 11'd0;
            r1_vcount  <= 11'd0;
            r1_hsync   <= 1'b0;
            r1_vsync   <= 1'b0;
            r1_hblnk   <= 1'b0;
            r1_vblnk   <= 1'b0;
            r1_rgb     <= 12'h000;
            r1_mode    <= MODE_START;
            r1_in_box  <= 1'b0;
            r1_text_on <= 1'b0;
        end else begin
            r1_hcount  <= vga_in_hcount;
            r1_vcount  <= vga_in_vcount;
            r1_hsync   <= vga_in_hsync;
            r1_vsync   <= vga_in_vsync;
            r1_hblnk   <= vga_in_hblnk;
            r1_vblnk   <= vga_in_vblnk;
            r1_rgb     <= vga_in_rgb;
            r1_mode    <= w_mode;
            r1_in_box  <= w_in_box;
            r1_text_on <= w_text_on;
        end
    end

    // ---------------- stage 2: colour mux ----------------
    logic [11:0] w_rgb_mux;

    // Pick pass-through, dimmed, box or text colour for the stage-1 pixel.
    always_comb begin
        w_rgb_mux = r1_rgb;
        case (r1_mode)
            MODE_PLAY: begin
                w_rgb_mux = r1_rgb;
            end
            MODE_PAUSE: begin
                if (r1_in_box) begin
                    w_rgb_mux = r1_text_on ? FG : BG;
                end else begin
                    w_rgb_mux = dim_rgb(r1_rgb);
                end
            end
            default: begin
                if (r1_in_box) begin
                    w_rgb_mux = r1_text_on ? FG : BG;
                end else begin
                    w_rgb_mux = r1_rgb;
                end
            end
        endcase
    end

    // Stage 2 register: drives every vga_out field.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_out_hcount <= 11'd0;
            vga_out_vcount <= 11'd0;
            vga_out_hsync  <= 1'b0;
            vga_out_vsync  <= 1'b0;
            vga_out_hblnk  <= 1'b0;
            vga_out_vblnk  <= 1'b0;
            vga_out_rgb    <= 12'h000;
        end else begin
            vga_out_hcount <= r1_hcount;
            vga_out_vcount <= r1_vcount;
            vga_out_hsync  <= r1_hsync;
            vga_out_vsync  <= r1_vsync;
            vga_out_hblnk  <= r1_hblnk;
            vga_out_vblnk  <= r1_vblnk;
            vga_out_rgb    <= w_rgb_mux;
        end
    end

endmodule

// File: tb/tb_game_overlay.sv
// Self-checking bench for game_overlay: reset behaviour, a table of
// hand-computed pixels, mid-frame mode change, optional blink, and random
// frames compared against an arithmetic model of the overlay rules.
module tb_game_overlay;

    localparam int BF = 2;
    localparam int RX = 256, RY = 256, RW = 512, RH = 256;
    localparam int TX = RX + 32, TY = RY + 64, SC = 4;
    localparam logic [11:0] FGC = 12'hFF0, BGC = 12'h000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  game_active = 2'd0;
    logic [10:0] in_h = 11'd10, in_v = 11'd10;
    logic        in_hs = 1'b0, in_vs = 1'b0, in_hb = 1'b0, in_vb = 1'b0;
    logic [11:0] in_rgb = 12'hABC;
    logic [10:0] out_h, out_v;
    logic        out_hs, out_vs, out_hb, out_vb;
    logic [11:0] out_rgb;

    always #5 clk = ~clk;

    game_overlay #(.BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .game_active(game_active),
        .vga_in_hcount(in_h), .vga_in_vcount(in_v),
        .vga_in_hsync(in_hs), .vga_in_vsync(in_vs),
        .vga_in_hblnk(in_hb), .vga_in_vblnk(in_vb), .vga_in_rgb(in_rgb),
        .vga_out_hcount(out_h), .vga_out_vcount(out_v),
        .vga_out_hsync(out_hs), .vga_out_vsync(out_vs),
        .vga_out_hblnk(out_hb), .vga_out_vblnk(out_vb), .vga_out_rgb(out_rgb)
    );

    typedef struct {
        logic [10:0] h, v;
        logic [3:0]  syn;
        logic [11:0] rgb;
    } pix_t;

    typedef struct {
        int          ga, h, v;
        logic [11:0] rgb, exp_rgb;
    } vec_t;

    pix_t exp_q[$];
    int   checks = 0, errors = 0;
    int   m_mode = 0, m_cnt = 0;

    function automatic logic [63:0] font(input byte c);
        case (c)
            "S": return 64'h3C66603C06663C00;
            "T": return 64'h7E18181818181800;
            "A": return 64'h183C66667E666600;
            "R": return 64'h7C66667C6C666600;
            "E": return 64'h7E60607C60607E00;
            "N": return 64'h66767E7E6E666600;
            "D": return 64'h786C6666666C7800;
            "P": return 64'h7C66667C60606000;
            "U": return 64'h6666666666663C00;
            default: return 64'h0;
        endcase
    endfunction

    // Expected colour of one pixel from the overlay rules.
    function automatic logic [11:0] ref_rgb(int mode, bit vis, int h, int v, logic [11:0] rgb);
        string msg;
        int ci, col, row;
        logic [63:0] g;
        if (mode == 1) return rgb;
        if (!(h >= RX && h < RX + RW && v >= RY && v < RY + RH)) begin
            if (mode == 3)
                return 12'((rgb[11:8] / 2) * 256 + (rgb[7:4] / 2) * 16 + rgb[3:0] / 2);
            return rgb;
        end
        if (mode == 0) msg = "START";
        else if (mode == 2) msg = "END";
        else msg = "PAUSE";
        if (vis && h >= TX && v >= TY) begin
            ci  = (h - TX) / (8 * SC);
            col = ((h - TX) / SC) % 8;
            row = ((v - TY) / SC) % 8;
            if (ci < msg.len()) begin
                g = font(msg[ci]);
                if (g[63 - (row * 8 + col)]) return FGC;
            end
        end
        return BGC;
    endfunction

    task automatic compare_front();
        pix_t e;
        e = exp_q.pop_front();
        checks++;
        if ({out_h, out_v, out_hs, out_vs, out_hb, out_vb, out_rgb} !==
            {e.h, e.v, e.syn, e.rgb}) begin
            errors++;
            $display("FAIL pixel(%0d,%0d): got h=%0d v=%0d sync=%b%b%b%b rgb=%h, want sync=%b rgb=%h",
                     e.h, e.v, out_h, out_v, out_hs, out_vs, out_hb, out_vb, out_rgb, e.syn, e.rgb);
        end
    endtask

    // Drive one pixel; output for the pixel two cycles back is checked first.
    task automatic step(input int ga, input int h, input int v, input logic [11:0] rgb,
                        input bit use_exp, input logic [11:0] exp_rgb);
        pix_t e;
        bit vis;
        @(negedge clk);
        if (exp_q.size() >= 2) compare_front();
        rst = 1'b0;
        game_active = 2'(ga);
        in_h = 11'(h);
        in_v = 11'(v);
        e.syn = 4'($urandom);
        {in_hs, in_vs, in_hb, in_vb} = e.syn;
        in_rgb = rgb;
        if (h == 0 && v == 0) begin
            if (ga != m_mode) begin
                m_mode = ga;
                m_cnt  = 0;
            end else begin
                m_cnt = (m_cnt + 1) % (2 * BF);
            end
        end
`ifdef GAME_OVERLAY_BLINK_EN
        vis = (m_cnt < BF);
`else
        vis = 1'b1;
`endif
        e.h = 11'(h);
        e.v = 11'(v);
        e.rgb = use_exp ? exp_rgb : ref_rgb(m_mode, vis, h, v, rgb);
        exp_q.push_back(e);
    endtask

    task automatic drain();
        repeat (2) begin
            @(negedge clk);
            if (exp_q.size() > 0) compare_front();
        end
    endtask

    vec_t tbl[$];

    initial begin
        tbl = '{
            '{0,   0,   0, 12'h123, 12'h123}, '{0, 256, 256, 12'h456, 12'h000},
            '{0, 288, 320, 12'h456, 12'h000}, '{0, 296, 320, 12'h456, 12'hFF0},
            '{0, 255, 300, 12'h456, 12'h456}, '{0, 767, 300, 12'h456, 12'h000},
            '{0, 768, 300, 12'h456, 12'h456}, '{0, 320, 320, 12'h456, 12'h000},
            '{0, 324, 320, 12'h456, 12'hFF0}, '{0, 452, 320, 12'h456, 12'h000},
            '{0, 296, 512, 12'h456, 12'h456}, '{0, 296, 511, 12'h456, 12'h000},
            '{3,   0,   0, 12'hFFF, 12'h777}, '{3, 100, 100, 12'hFFF, 12'h777},
            '{3, 288, 320, 12'hFFF, 12'h000}, '{3, 292, 320, 12'hFFF, 12'hFF0},
            '{3, 256, 256, 12'hFFF, 12'h000}, '{3, 900, 700, 12'hFFF, 12'h777},
            '{2,   0,   0, 12'hABC, 12'hABC}, '{2, 292, 320, 12'hABC, 12'hFF0},
            '{2, 388, 320, 12'hABC, 12'h000}, '{2, 356, 324, 12'hABC, 12'hFF0},
            '{1,   0,   0, 12'hABC, 12'hABC}, '{1, 296, 320, 12'hABC, 12'hABC},
            '{1, 100, 100, 12'hFFF, 12'hFFF}
        };

        // Reset: outputs all zero while held, then first pixel emerges 2 edges later.
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({out_h, out_v, out_hs, out_vs, out_hb, out_vb, out_rgb} !== 35'd0) begin
                errors++;
                $display("FAIL reset_zero: got rgb=%h h=%0d v=%0d, want all 0", out_rgb, out_h, out_v);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_rgb !== 12'h000) begin
            errors++;
            $display("FAIL reset_lat1: got rgb=%h, want 000", out_rgb);
        end
        @(negedge clk);
        checks++;
        if (out_rgb !== 12'hABC) begin
            errors++;
            $display("FAIL reset_lat2: got rgb=%h, want abc", out_rgb);
        end

        // Mode stays START after a mid-frame release even though PLAY is requested.
        step(1, 296, 320, 12'h111, 1'b1, 12'hFF0);
        step(1, 100, 100, 12'h222, 1'b1, 12'h222);

        // Hand-computed table.
        foreach (tbl[i]) step(tbl[i].ga, tbl[i].h, tbl[i].v, tbl[i].rgb, 1'b1, tbl[i].exp_rgb);

        // PLAY -> END requested mid-frame: no effect until the next frame start.
        step(1, 0, 0, 12'h010, 1'b1, 12'h010);
        step(1, 50, 300, 12'h020, 1'b1, 12'h020);
        step(2, 100, 300, 12'h321, 1'b1, 12'h321);
        step(2, 296, 320, 12'h555, 1'b1, 12'h555);
        step(2, 700, 700, 12'h666, 1'b1, 12'h666);
        step(2, 0, 0, 12'h0F0, 1'b1, 12'h0F0);
        step(2, 292, 320, 12'h0F0, 1'b1, 12'hFF0);

`ifdef GAME_OVERLAY_BLINK_EN
        // Blink: PLAY then START; frames 0-1 text, 2-3 box only, 4 text again.
        step(1, 0, 0, 12'h000, 1'b0, 12'h000);
        for (int f = 0; f < 5; f++) begin
            step(0, 0, 0, 12'h345, 1'b1, 12'h345);
            step(0, 296, 320, 12'h345, 1'b1, ((f % 4) < 2) ? 12'hFF0 : 12'h000);
            step(0, 256, 256, 12'h345, 1'b1, 12'h000);
        end
`endif

        // Random frames against the model; game_active also changes mid-frame.
        for (int f = 0; f < 40; f++) begin
            step(int'($urandom_range(3, 0)), 0, 0, 12'($urandom), 1'b0, 12'h000);
            for (int p = 0; p < 150; p++) begin
                int h, v, ga;
                h  = ($urandom_range(1, 0) == 0) ? int'($urandom_range(780, 250)) : int'($urandom_range(1023, 0));
                v  = ($urandom_range(1, 0) == 0) ? int'($urandom_range(520, 250)) : int'($urandom_range(767, 0));
                ga = ($urandom_range(9, 0) == 0) ? int'($urandom_range(3, 0)) : m_mode;
                step(ga, h, v, 12'($urandom), 1'b0, 12'h000);
            end
        end

        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_overlay.md
GAME_OVERLAY -- requirements
Module: game_overlay

Interface
REQ-001 Parameter RECT_X, default HOR_PIXELS/4, left edge of the message box in pixels.
REQ-002 Parameter RECT_Y, default VER_PIXELS/3, top edge of the message box in pixels.
REQ-003 Parameter RECT_W, default HOR_PIXELS/2, box width in pixels.
REQ-004 Parameter RECT_H, default VER_PIXELS/3, box height in pixels.
REQ-005 Parameter TXT_DX, default 32, text origin x offset inside the box.
REQ-006 Parameter TXT_DY, default 64, text origin y offset inside the box.
REQ-007 Parameter SCALE_LOG2, default 2, glyph magnification 2^SCALE_LOG2; legal values are 0..3.
REQ-008 Parameter BLINK_FRAMES, default 30, frames per blink half-period; minimum 1.
REQ-009 Parameter FG, default 12'hFF0, text colour.
REQ-010 Parameter BG, default 12'h000, box colour.
REQ-011 clk  input  1  pixel clock; all state on its rising edge.
REQ-012 rst  input  1  asynchronous, active-high reset.
REQ-013 game_active  input  2  0=START, 1=PLAY, 2=END, 3=PAUSE.
REQ-014 vga_in  vga_if.in  bundle  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb[11:0].
REQ-015 vga_out  vga_if.out  bundle  same fields as vga_in, after overlay.

Function
REQ-016 All vga_out fields SHALL be delayed exactly 2 clk cycles from vga_in: stage 1 is the glyph/region decode, stage 2 is the colour mux.
REQ-017 A frame start SHALL be the cycle in which vga_in.hcount==0 and vga_in.vcount==0.
REQ-018 mode_q SHALL load game_active only at a frame start; game_active changes mid-frame SHALL have no effect until the next frame start.
REQ-019 In PLAY, vga_out.rgb SHALL equal vga_in.rgb, delayed 2 cycles.
REQ-020 In START, END or PAUSE, a pixel inside the box (RECT_X<=h<RECT_X+RECT_W, RECT_Y<=v<RECT_Y+RECT_H) SHALL be BG, or FG where a glyph bit is set and the text is visible.
REQ-021 Message strings: START="START", END="END", PAUSE="PAUSE"; characters beyond the string length SHALL produce no text.
REQ-022 Glyphs SHALL come from an internal 8x8 font ROM covering S,T,A,R,E,N,D,P,U; each glyph cell is 8<<SCALE_LOG2 pixels square.
REQ-023 Character index SHALL be (h-TX)>>(3+SCALE_LOG2), where TX=RECT_X+TXT_DX; the glyph column is ((h-TX)>>SCALE_LOG2)&7 and the glyph row is ((v-TY)>>SCALE_LOG2)&7, where TY=RECT_Y+TXT_DY.
REQ-024 Pixels with h<TX or v<TY SHALL be treated as non-text; the comparison SHALL be made before subtraction so that no unsigned wrap occurs.
REQ-025 Text SHALL be clipped to the box; glyph pixels outside the box are never drawn.
REQ-026 In PAUSE, pixels outside the box SHALL be dimmed, each 4-bit channel shifted right by 1 (12'hFFF becomes 12'h777); in START and END, pixels outside the box SHALL pass through unchanged.
REQ-027 frame_cnt SHALL increment at every frame start and wrap from 2*BLINK_FRAMES-1 to 0; blink_on = (frame_cnt < BLINK_FRAMES).
REQ-028 When mode_q changes value at a frame start, frame_cnt SHALL be cleared to 0 in the same cycle, so the text is visible immediately.
REQ-029 Sync and blank fields (hsync, vsync, hblnk, vblnk, hcount, vcount) SHALL pass through unmodified, delayed 2 cycles.

Reset
REQ-030 On rst=1, all vga_out fields and both pipeline stages SHALL clear to 0, frame_cnt SHALL clear to 0, and mode_q SHALL be set to START, all asynchronously.
REQ-031 After a mid-frame deassertion of rst, vga_out SHALL carry valid data from the 2nd rising edge onward, and mode_q SHALL hold START until the next frame start.

Configuration
REQ-032 With macro GAME_OVERLAY_BLINK_EN defined, text SHALL be visible only while blink_on=1 and the box shows BG otherwise; without the macro, text SHALL be always visible and frame_cnt and the blink logic SHALL be absent.

Verification
REQ-033 Reset held for 5 cycles then released, vga_in.rgb=12'hABC -> vga_out all 0 during reset; rgb=12'hABC exactly 2 cycles after the first clocked pixel.
REQ-034 game_active=1 for a full frame with a random rgb pattern -> vga_out.rgb equals vga_in.rgb delayed 2 at every pixel.
REQ-035 game_active=0 with default parameters -> pixel (RECT_X+TXT_DX, RECT_Y+TXT_DY) shows the S glyph bit colour, (RECT_X, RECT_Y) = 12'h000, (0,0) = input rgb.
REQ-036 game_active=3, vga_in.rgb=12'hFFF -> outside the box vga_out.rgb=12'h777, inside the box BG/FG per the "PAUSE" glyphs.
REQ-037 game_active switched from 1 to 2 at hcount=100, vcount=300 -> the rest of that frame is pass-through; the END overlay appears from the next frame start.
REQ-038 GAME_OVERLAY_BLINK_EN defined, BLINK_FRAMES=2, game_active=0 -> text visible in frames 0-1, box-only in frames 2-3, visible again in frame 4.
